// File: rtl/weight_tile_loader.sv
// weight_tile_loader
//
// Receive side of the weight-SRAM read stream. Read data returns one cycle
// after the read is issued. Each returned word is one row of MAC_COL weights,
// and the loader collects these rows into a shadow tile of MAC_ROW rows. A
// swap request copies the complete shadow tile into the active bank that feeds
// the MAC array. Because of this double buffering, the next tile can prefetch
// while the current tile computes.
//
// Ports:
//   clk              system clock, rising edge
//   rstn             asynchronous active-low reset
//   w_prefetch_in    pulse, start filling a new shadow tile
//   w_read_en_in     SRAM read issued this cycle (data returns next cycle)
//   w_rdata_in       SRAM read data, MAC_COL weights of W_BITWIDTH bits
//   swap_req_in      pulse, request shadow -> active commit
//   w_active_out     active tile, row r at [r*MAC_COL*W_BITWIDTH +: MAC_COL*W_BITWIDTH]
//   active_valid_out active bank holds at least one committed tile
//   swap_done_out    one-cycle pulse in the cycle after a commit
//   swap_stall_out   swap request pending while the shadow is still filling
//   shadow_full_out  shadow holds MAC_ROW rows
//   overflow_err_out sticky, read data arrived while the shadow was full
//   tile_cnt_out     committed tile count, wraps
module weight_tile_loader #(
    parameter int MAC_ROW      = 16,
    parameter int MAC_COL      = 16,
    parameter int W_BITWIDTH   = 8,
    parameter int TILE_CNT_BIT = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  w_prefetch_in,
    input  logic                                  w_read_en_in,
    input  logic [W_BITWIDTH*MAC_COL-1:0]         w_rdata_in,
    input  logic                                  swap_req_in,
    output logic [MAC_ROW*MAC_COL*W_BITWIDTH-1:0] w_active_out,
    output logic                                  active_valid_out,
    output logic                                  swap_done_out,
    output logic                                  swap_stall_out,
    output logic                                  shadow_full_out,
    output logic                                  overflow_err_out,
    output logic [TILE_CNT_BIT-1:0]               tile_cnt_out
);

    localparam int ROW_W = MAC_COL * W_BITWIDTH;
    localparam int PTR_W = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(MAC_ROW - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } swap_state_t;

    swap_state_t state, state_next;

    logic [MAC_ROW-1:0][ROW_W-1:0] shadow;
    logic [MAC_ROW-1:0][ROW_W-1:0] active;
    logic [PTR_W-1:0]              wr_ptr;
    logic                          shadow_full;
    logic                          rvalid;
    logic                          commit;
    logic [PTR_W-1:0]              eff_ptr;
    logic                          eff_full;

    assign w_active_out    = active;
    assign swap_stall_out  = (state == S_WAIT);
    assign shadow_full_out = shadow_full;

    // Swap state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Swap control. A request that finds the shadow full commits at once.
    // Otherwise the FSM holds a single pending request and commits on the
    // first edge that sees the registered full flag set.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (swap_req_in) begin
                    if (shadow_full) begin
                        commit = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (shadow_full) begin
                    commit     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A prefetch restarts the fill before the incoming word is placed. As a
    // result, a word that returns in the same cycle lands in row 0.
    always_comb begin
        eff_ptr  = wr_ptr;
        eff_full = shadow_full;
        if (w_prefetch_in) begin
            eff_ptr  = '0;
            eff_full = 1'b0;
        end
    end

    // Fill datapath, active bank and status. The commit copies the pre-edge
    // shadow. A word that returns while the shadow is full is dropped, and
    // this is flagged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow           <= '0;
            active           <= '0;
            wr_ptr           <= '0;
            shadow_full      <= 1'b0;
            rvalid           <= 1'b0;
            active_valid_out <= 1'b0;
            swap_done_out    <= 1'b0;
            overflow_err_out <= 1'b0;
            tile_cnt_out     <= '0;
        end else begin
            rvalid        <= w_read_en_in;
            swap_done_out <= commit;

            if (commit) begin
                active           <= shadow;
                active_valid_out <= 1'b1;
                tile_cnt_out     <= tile_cnt_out + 1'b1;
            end

            if (rvalid && !eff_full) begin
                shadow[eff_ptr] <= w_rdata_in;
                if (eff_ptr == LAST_ROW) begin
                    wr_ptr      <= eff_ptr;
                    shadow_full <= 1'b1;
                end else begin
                    wr_ptr      <= eff_ptr + 1'b1;
                    shadow_full <= 1'b0;
                end
            end else begin
                if (rvalid) begin
                    overflow_err_out <= 1'b1;
                end
                if (commit) begin
                    wr_ptr      <= '0;
                    shadow_full <= 1'b0;
                end else begin
                    wr_ptr      <= eff_ptr;
                    shadow_full <= eff_full;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_tile_loader.sv
// tb_weight_tile_loader
//
// Drives weight_tile_loader with directed scenarios and a randomized phase.
// Every cycle, the outputs are compared against a reference model that tracks
// the shadow tile as an array plus a row count, together with pending, full
// and overflow flags.
module tb_weight_tile_loader;

    localparam int MAC_ROW      = 16;
    localparam int MAC_COL      = 16;
    localparam int W_BITWIDTH   = 8;
    localparam int TILE_CNT_BIT = 16;
    localparam int ROW_W        = MAC_COL * W_BITWIDTH;

    logic                                  clk = 1'b0;
    logic                                  rstn;
    logic                                  w_prefetch_in;
    logic                                  w_read_en_in;
    logic [ROW_W-1:0]                      w_rdata_in;
    logic                                  swap_req_in;
    logic [MAC_ROW*MAC_COL*W_BITWIDTH-1:0] w_active_out;
    logic                                  active_valid_out;
    logic                                  swap_done_out;
    logic                                  swap_stall_out;
    logic                                  shadow_full_out;
    logic                                  overflow_err_out;
    logic [TILE_CNT_BIT-1:0]               tile_cnt_out;

    weight_tile_loader #(
        .MAC_ROW      (MAC_ROW),
        .MAC_COL      (MAC_COL),
        .W_BITWIDTH   (W_BITWIDTH),
        .TILE_CNT_BIT (TILE_CNT_BIT)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .w_prefetch_in    (w_prefetch_in),
        .w_read_en_in     (w_read_en_in),
        .w_rdata_in       (w_rdata_in),
        .swap_req_in      (swap_req_in),
        .w_active_out     (w_active_out),
        .active_valid_out (active_valid_out),
        .swap_done_out    (swap_done_out),
        .swap_stall_out   (swap_stall_out),
        .shadow_full_out  (shadow_full_out),
        .overflow_err_out (overflow_err_out),
        .tile_cnt_out     (tile_cnt_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [ROW_W-1:0] m_shadow [MAC_ROW];
    logic [ROW_W-1:0] m_active [MAC_ROW];
    int               m_rows;
    bit               m_full, m_pending, m_rvalid, m_valid, m_done, m_ovf;
    int unsigned      m_tiles;
    logic [ROW_W-1:0] ret_word;

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] got,
                               input logic [ROW_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < MAC_ROW; r++) begin
            m_shadow[r] = '0;
            m_active[r] = '0;
        end
        m_rows = 0; m_full = 0; m_pending = 0; m_rvalid = 0;
        m_valid = 0; m_done = 0; m_ovf = 0; m_tiles = 0;
    endtask

    // Model one clock edge from the pre-edge state and the inputs currently driven
    task automatic modelEdge(input bit pf, input bit sw, input logic [ROW_W-1:0] data);
        bit full0, commit;
        full0  = m_full;
        commit = m_pending ? full0 : (sw && full0);
        if (commit) begin
            for (int r = 0; r < MAC_ROW; r++) m_active[r] = m_shadow[r];
            m_valid = 1;
            m_tiles++;
        end
        m_pending = m_pending ? !full0 : (sw && !full0);
        m_done    = commit;
        if (m_rvalid && full0 && !pf) m_ovf = 1;
        if (pf || commit) begin
            m_rows = 0;
            m_full = 0;
        end
        if (m_rvalid && (pf || !full0)) begin
            m_shadow[m_rows] = data;
            m_rows++;
            if (m_rows == MAC_ROW) m_full = 1;
        end
    endtask

    task automatic checkAll();
        checkOutput("active_valid", ROW_W'(active_valid_out), ROW_W'(m_valid));
        checkOutput("swap_done", ROW_W'(swap_done_out), ROW_W'(m_done));
        checkOutput("swap_stall", ROW_W'(swap_stall_out), ROW_W'(m_pending));
        checkOutput("shadow_full", ROW_W'(shadow_full_out), ROW_W'(m_full));
        checkOutput("overflow", ROW_W'(overflow_err_out), ROW_W'(m_ovf));
        checkOutput("tile_cnt", ROW_W'(tile_cnt_out), ROW_W'(TILE_CNT_BIT'(m_tiles)));
        for (int r = 0; r < MAC_ROW; r++)
            checkOutput($sformatf("active_row%0d", r), w_active_out[r*ROW_W +: ROW_W], m_active[r]);
    endtask

    function automatic logic [ROW_W-1:0] randWord();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [ROW_W-1:0] repByte(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {MAC_COL{b}};
    endfunction

    // One cycle of stimulus. If a read is issued, word is the data returned next cycle.
    task automatic applyStimulus(input bit pf, input bit rd, input bit sw,
                                 input logic [ROW_W-1:0] word);
        @(negedge clk);
        w_prefetch_in = pf;
        w_read_en_in  = rd;
        swap_req_in   = sw;
        w_rdata_in    = m_rvalid ? ret_word : randWord();
        ret_word      = word;
        modelEdge(pf, sw, w_rdata_in);
        m_rvalid = rd;
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rstn          = 1'b0;
        w_prefetch_in = 1'b0;
        w_read_en_in  = 1'b0;
        swap_req_in   = 1'b0;
        w_rdata_in    = '0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int stall_cycles;

    initial begin
        rstn = 1'b1;
        w_prefetch_in = 1'b0; w_read_en_in = 1'b0; swap_req_in = 1'b0; w_rdata_in = '0;
        ret_word = '0;
        modelReset();

        // 1: full tile of row-index patterns, then swap
        doReset();
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < MAC_ROW; r++) applyStimulus(0, 1, 0, repByte(r));
        applyStimulus(0, 0, 0, '0);
        checkOutput("t1_full", ROW_W'(shadow_full_out), ROW_W'(1));
        applyStimulus(0, 0, 1, '0);
        checkOutput("t1_done", ROW_W'(swap_done_out), ROW_W'(1));
        checkOutput("t1_row5", w_active_out[5*ROW_W +: ROW_W], repByte(5));
        idle(1);
        checkOutput("t1_done_low", ROW_W'(swap_done_out), ROW_W'(0));
        checkOutput("t1_tiles", ROW_W'(tile_cnt_out), ROW_W'(1));

        // 2: swap requested after 10 rows, stall until the tile completes
        doReset();
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < 10; r++) applyStimulus(0, 1, 0, randWord());
        stall_cycles = 0;
        for (int r = 10; r < MAC_ROW; r++) begin
            applyStimulus(0, 1, (r == 10), randWord());
            if (swap_stall_out) stall_cycles++;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0);
            if (swap_stall_out) stall_cycles++;
        end
        checkOutput("t2_stall_len", ROW_W'(stall_cycles >= 6), ROW_W'(1));
        checkOutput("t2_tiles", ROW_W'(tile_cnt_out), ROW_W'(1));

        // 3: 17 reads after one prefetch, 17th dropped, overflow sticky
        doReset();
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < MAC_ROW + 1; r++) applyStimulus(0, 1, 0, repByte(r + 1));
        idle(2);
        checkOutput("t3_overflow", ROW_W'(overflow_err_out), ROW_W'(1));
        applyStimulus(0, 0, 1, '0);
        idle(1);
        checkOutput("t3_row15", w_active_out[15*ROW_W +: ROW_W], repByte(16));
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < MAC_ROW; r++) applyStimulus(0, 1, 0, randWord());
        idle(1);
        applyStimulus(0, 0, 1, '0);
        idle(2);
        checkOutput("t3_overflow_sticky", ROW_W'(overflow_err_out), ROW_W'(1));

        // 4: abandon a partial fill, prefetch coincident with a read return
        doReset();
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < 5; r++) applyStimulus(0, 1, 0, randWord());
        applyStimulus(0, 1, 0, repByte(8'hA5));
        applyStimulus(1, 1, 0, repByte(8'hA5));
        for (int r = 0; r < MAC_ROW - 2; r++) applyStimulus(0, 1, 0, repByte(8'hA5));
        applyStimulus(0, 0, 0, '0);
        checkOutput("t4_full", ROW_W'(shadow_full_out), ROW_W'(1));
        applyStimulus(0, 0, 1, '0);
        idle(1);
        checkOutput("t4_row0", w_active_out[0 +: ROW_W], repByte(8'hA5));
        checkOutput("t4_row15", w_active_out[15*ROW_W +: ROW_W], repByte(8'hA5));

        // 5: back-to-back tiles, active holds while the shadow refills
        doReset();
        for (int t = 0; t < 2; t++) begin
            applyStimulus(1, 0, 0, '0);
            for (int r = 0; r < MAC_ROW; r++) applyStimulus(0, 1, 0, randWord());
            idle(2);
            applyStimulus(0, 0, 1, '0);
        end
        idle(2);
        checkOutput("t5_tiles", ROW_W'(tile_cnt_out), ROW_W'(2));

        // 6: reset while waiting after 8 rows, then a normal tile
        doReset();
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < 8; r++) applyStimulus(0, 1, 0, randWord());
        applyStimulus(0, 0, 1, '0);
        idle(2);
        checkOutput("t6_waiting", ROW_W'(swap_stall_out), ROW_W'(1));
        doReset();
        checkOutput("t6_stall_cleared", ROW_W'(swap_stall_out), ROW_W'(0));
        applyStimulus(1, 0, 0, '0);
        for (int r = 0; r < MAC_ROW; r++) applyStimulus(0, 1, 0, randWord());
        applyStimulus(0, 0, 1, '0);
        idle(3);
        checkOutput("t6_tiles", ROW_W'(tile_cnt_out), ROW_W'(1));

        // Randomized traffic
        doReset();
        for (int i = 0; i < 600; i++)
            applyStimulus(($urandom % 20) == 0, ($urandom % 4) != 0,
                          ($urandom % 12) == 0, randWord());

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
